operand_feeder: RTL

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/feeder_pkg.sv | 14 +
 rtl/feeder_fifo.sv | 58 +++++
 rtl/operand_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// Shared constants and FSM state encoding for the operand feeder.
package feeder_pkg;

    localparam int FEEDER_DEPTH = 8;
    localparam int FEEDER_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GO        = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Operand storage: single-clock FIFO with count, full/empty flags and a
// combinational head word.
module feeder_fifo
    import feeder_pkg::*;
#(
    parameter int DEPTH = FEEDER_DEPTH,
    parameter int WIDTH = FEEDER_WIDTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Streams zero-terminated operand lists from a FIFO to an accumulator and
// captures the accumulator's result for each list.
module operand_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH = FEEDER_DEPTH,
    parameter int WIDTH = FEEDER_WIDTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] inA,
    output logic             go_l,
    input  logic             done,
    input  logic [WIDTH-1:0] outResult,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [CW-1:0]    dbg_count
);

    // Handshake: a word transfers on a rising clk edge where in_valid and
    // in_ready are both high; in_ready does not depend on in_valid.

    feeder_state_t    state, next_state;
    logic [CW-1:0]    term_cnt;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_data;
    logic             push;
    logic             pop;
    logic             pop_req;
    logic             push_zero;
    logic             pop_zero;
    logic [WIDTH-1:0] next_inA;
    logic             next_go_l;
    logic [WIDTH-1:0] next_result;
    logic             next_result_valid;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = pop_req && !fifo_empty;
    assign push_zero = push && (in_data == '0);
    assign pop_zero  = pop && (head_data == '0);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign dbg_count = fifo_count;

    feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_l   (reset_l),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Number of complete lists waiting: one terminator per list.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            term_cnt <= '0;
        end else begin
            case ({push_zero, pop_zero})
                2'b10:   term_cnt <= term_cnt + CW'(1);
                2'b01:   term_cnt <= term_cnt - CW'(1);
                default: term_cnt <= term_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ST_IDLE;
            inA          <= '0;
            go_l         <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= next_state;
            inA          <= next_inA;
            go_l         <= next_go_l;
            result       <= next_result;
            result_valid <= next_result_valid;
        end
    end

    // inA holds the word currently on the bus, so a zero in GO/STREAM means
    // the terminator has just been driven.
    always_comb begin
        next_state        = state;
        next_inA          = '0;
        next_go_l         = 1'b1;
        next_result       = result;
        next_result_valid = 1'b0;
        pop_req           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (term_cnt != '0) begin
                    pop_req    = 1'b1;
                    next_inA   = head_data;
                    next_go_l  = 1'b0;
                    next_state = ST_GO;
                end
            end
            ST_GO, ST_STREAM: begin
                if (inA == '0) begin
                    next_state = ST_WAIT_DONE;
                end else begin
                    pop_req    = 1'b1;
                    next_inA   = head_data;
                    next_state = ST_STREAM;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    next_result       = outResult;
                    next_result_valid = 1'b1;
                    next_state        = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
